hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1, rising-edge system clock; reset in 1, asynchronous active-high reset.
REQ-002 RA1D, RA2D in 4 each: Decode-stage register-file read addresses.
REQ-003 WA3D in 4: Decode-stage destination register address.
REQ-004 MemtoRegE in 1: instruction in Execute is a load.
REQ-005 RegWriteM, RegWriteW in 1 each: condition-qualified register write in Memory and Writeback.
REQ-006 PCSrcD, PCSrcE, PCSrcM, PCSrcW in 1 each: PC-writing instruction in that stage.
REQ-007 BranchTakenE in 1: branch resolved taken in Execute.
REQ-008 ForwardAE, ForwardBE out 2 each: SrcA/SrcB forward select, 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
REQ-009 StallF, StallD out 1 each: hold the Fetch PC register and the Decode pipeline register.
REQ-010 FlushD, FlushE out 1 each: clear the Decode and Execute pipeline registers. FlushE drives the controller's FlushE input.

Function
REQ-011 Internal shadow pipeline: D->E stage holds RA1E, RA2E, WA3E and validE; E->M holds WA3M, validM; M->W holds WA3W, validW.
REQ-012 D->E stage: on each clk edge, load RA1D/RA2D/WA3D with validE=1. When FlushE=1, clear to zero with validE=0. FlushE takes priority over load.
REQ-013 E->M and M->W stages: unconditional copy every edge, with no stall or flush.
REQ-014 ForwardAE=10 when validM & RegWriteM & RA1E==WA3M & RA1E!=15.
REQ-015 Otherwise ForwardAE=01 when validW & RegWriteW & RA1E==WA3W & RA1E!=15. Otherwise 00. The Memory match has priority over the Writeback match.
REQ-016 ForwardBE uses the identical rule on RA2E.
REQ-017 LDRstall = validE & MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
REQ-018 PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
REQ-019 StallF = LDRstall | PCWrPendingF.
REQ-020 StallD = LDRstall.
REQ-021 FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
REQ-022 FlushE = LDRstall | BranchTakenE.
REQ-023 All outputs SHALL be combinational from the inputs and the shadow state, with zero-cycle latency.
REQ-024 Load-use latency: exactly one bubble is inserted. The cycle after LDRstall, validE=0 and LDRstall deasserts unless a new load hazard exists.
REQ-025 When LDRstall and BranchTakenE are asserted simultaneously, FlushE=1 and FlushD=1. The branch flush dominates, and StallD still holds D so that D is flushed, not re-executed.

Reset
REQ-026 Reset SHALL clear all shadow registers to 0 and all valid bits to 0.
REQ-027 While reset is asserted, the outputs SHALL be: ForwardAE=ForwardBE=00, StallF=StallD=0, FlushE=BranchTakenE, FlushD as defined in REQ-021.
REQ-028 Reset asserted mid-stall SHALL drop LDRstall immediately, because validE=0.

Structure
REQ-029 A shared package SHALL hold the forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the PC register index 4'd15.
REQ-030 The D->E shadow stage SHALL instantiate the existing floprc (clear = FlushE). The E->M and M->W stages SHALL instantiate flopr. No other sub-module is used.

Verification
REQ-031 Scenario: ADD R1 in M with RegWriteM=1, RA1E=1, validM=1 -> ForwardAE=10. With the same R1 in W only -> ForwardAE=01. Both asserted -> 10.
REQ-032 Scenario: LDR R2 in E (MemtoRegE=1, WA3E=2), RA2D=2 -> StallF=StallD=FlushE=1 for one cycle. The next cycle all are 0 and ForwardBE=01 when the load reaches W.
REQ-033 Scenario: PCSrcD=1 marched through D/E/M/W -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles, then all 0.
REQ-034 Scenario: BranchTakenE=1 together with LDRstall -> FlushD=1 and FlushE=1, and the next cycle validE=0 with no forwarding.
REQ-035 Scenario: RA1E=15 with WA3M=15 and RegWriteM=1 -> ForwardAE=00.
REQ-036 Scenario: reset asserted during an active load stall -> StallF=StallD=0 in the same cycle, and the shadow valid bits read 0 after release.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_pkg
// Description : Shared constants and the operand-forwarding select helper
//               for the pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;   // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;   // operand from Writeback result
    localparam logic [1:0] FWD_MEM = 2'b10;   // operand from Memory ALU result

    localparam logic [3:0] PC_IDX  = 4'd15;   // R15 reads the PC, never forwarded

    // Forward select for one Execute source: Memory match beats Writeback.
    function automatic logic [1:0] fwd_select(
        input logic [3:0] ra,
        input logic [3:0] wa_m,
        input logic       valid_m,
        input logic       regwrite_m,
        input logic [3:0] wa_w,
        input logic       valid_w,
        input logic       regwrite_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (valid_m && regwrite_m && (ra == wa_m) && (ra != PC_IDX)) begin
            sel = FWD_MEM;
        end else if (valid_w && regwrite_w && (ra == wa_w) && (ra != PC_IDX)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage : hazard_unit_pkg
`default_nettype wire

// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_if
// Description : Bundle of pipeline status inputs and hazard control outputs
//               exchanged between the datapath/controller and hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_unit_if;

    logic [3:0] RA1D;
    logic [3:0] RA2D;
    logic [3:0] WA3D;
    logic       MemtoRegE;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       PCSrcD;
    logic       PCSrcE;
    logic       PCSrcM;
    logic       PCSrcW;
    logic       BranchTakenE;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;

    // Pipeline side: supplies stage status, consumes hazard controls.
    modport master (
        output RA1D, RA2D, WA3D, MemtoRegE, RegWriteM, RegWriteW,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );

    // Hazard unit side.
    modport slave (
        input  RA1D, RA2D, WA3D, MemtoRegE, RegWriteM, RegWriteW,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
    );

endinterface : hazard_unit_if
`default_nettype wire

// File: rtl/flopr.sv
`default_nettype none
// ============================================================================
// Module      : flopr
// Description : Resettable register, asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module flopr #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    // Plain register, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule : flopr
`default_nettype wire

// File: rtl/floprc.sv
`default_nettype none
// ============================================================================
// Module      : floprc
// Description : Resettable register with synchronous clear; clear beats load.
// Revision    : 1.0 - initial release
// ============================================================================
module floprc #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    // Register with async reset and sync clear taking priority over load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      q <= '0;
        else if (clear) q <= '0;
        else            q <= d;
    end

endmodule : floprc
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard unit. Tracks register addresses through a
//               shadow E/M/W pipeline and produces operand forwarding,
//               load-use stalls and control-hazard flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_unit_pkg::*;
(
    input wire logic     clk,
    input wire logic     reset,
    hazard_unit_if.slave hz
);

    logic [3:0] RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       validE, validM, validW;
    logic       LDRstall;
    logic       PCWrPendingF;
    logic       flush_e;

    // D->E shadow stage: the bubble inserted by FlushE also drops validE.
    floprc #(.WIDTH(13)) u_shadow_de (
        .clk   (clk),
        .reset (reset),
        .clear (flush_e),
        .d     ({hz.RA1D, hz.RA2D, hz.WA3D, 1'b1}),
        .q     ({RA1E, RA2E, WA3E, validE})
    );

    // E->M shadow stage, never stalled or flushed.
    flopr #(.WIDTH(5)) u_shadow_em (
        .clk   (clk),
        .reset (reset),
        .d     ({WA3E, validE}),
        .q     ({WA3M, validM})
    );

    // M->W shadow stage, never stalled or flushed.
    flopr #(.WIDTH(5)) u_shadow_mw (
        .clk   (clk),
        .reset (reset),
        .d     ({WA3M, validM}),
        .q     ({WA3W, validW})
    );

    // Hazard detection; validE clears asynchronously, so reset kills a stall at once.
    always_comb begin
        LDRstall     = validE & hz.MemtoRegE & ((hz.RA1D == WA3E) | (hz.RA2D == WA3E));
        PCWrPendingF = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
        flush_e      = LDRstall | hz.BranchTakenE;
    end

    // Output decode; StallF is masked in reset so a pending PC write cannot freeze Fetch.
    always_comb begin
        hz.ForwardAE = fwd_select(RA1E, WA3M, validM, hz.RegWriteM,
                                  WA3W, validW, hz.RegWriteW);
        hz.ForwardBE = fwd_select(RA2E, WA3M, validM, hz.RegWriteM,
                                  WA3W, validW, hz.RegWriteW);
        hz.StallF    = (LDRstall | PCWrPendingF) & ~reset;
        hz.StallD    = LDRstall;
        hz.FlushD    = PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
        hz.FlushE    = flush_e;
    end

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed stimulus with hand-computed expectations queued to a
//               scoreboard; an independent monitor compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    logic clk;
    logic reset;
    logic done;

    hazard_unit_if hz ();

    hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}
    logic [7:0] exp_q[$];
    string      name_q[$];

    int total;
    int bad;

    // Drive one cycle of inputs; pcs = {PCSrcD, PCSrcE, PCSrcM, PCSrcW}
    task automatic drive(input logic rst_v, input logic [3:0] ra1, input logic [3:0] ra2,
                         input logic [3:0] wa3, input logic mtr, input logic rwm,
                         input logic rww, input logic [3:0] pcs, input logic bt);
        @(posedge clk);
        #1;
        reset           = rst_v;
        hz.RA1D         = ra1;
        hz.RA2D         = ra2;
        hz.WA3D         = wa3;
        hz.MemtoRegE    = mtr;
        hz.RegWriteM    = rwm;
        hz.RegWriteW    = rww;
        hz.PCSrcD       = pcs[3];
        hz.PCSrcE       = pcs[2];
        hz.PCSrcM       = pcs[1];
        hz.PCSrcW       = pcs[0];
        hz.BranchTakenE = bt;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                              input logic sf, input logic sd, input logic fd, input logic fe);
        exp_q.push_back({fa, fb, sf, sd, fd, fe});
        name_q.push_back(nm);
    endtask

    // Monitor: compares every queued expectation against the DUT mid-cycle.
    initial begin
        logic [7:0] e;
        logic [7:0] a;
        string      nm;
        total = 0;
        bad   = 0;
        while (!done) begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got FA=%b FB=%b SF=%b SD=%b FD=%b FE=%b, expected FA=%b FB=%b SF=%b SD=%b FD=%b FE=%b",
                             nm, a[7:6], a[5:4], a[3], a[2], a[1], a[0],
                             e[7:6], e[5:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // Stimulus: each drive is followed by the hand-derived outputs for that cycle.
    initial begin
        done            = 1'b0;
        reset           = 1'b1;
        hz.RA1D         = '0;
        hz.RA2D         = '0;
        hz.WA3D         = '0;
        hz.MemtoRegE    = 1'b0;
        hz.RegWriteM    = 1'b0;
        hz.RegWriteW    = 1'b0;
        hz.PCSrcD       = 1'b0;
        hz.PCSrcE       = 1'b0;
        hz.PCSrcM       = 1'b0;
        hz.PCSrcW       = 1'b0;
        hz.BranchTakenE = 1'b0;

        // Reset behaviour
        drive(1, 0, 0, 0, 1, 1, 0, 4'b1000, 1);
        expect_out("reset_outputs", 2'b00, 2'b00, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        expect_out("reset_idle", 2'b00, 2'b00, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 1, 4'b0000, 0);
        expect_out("post_reset_valid", 2'b00, 2'b00, 0, 0, 0, 0);

        // Forwarding
        drive(0, 5, 6, 1, 0, 0, 0, 4'b0000, 0);
        drive(0, 1, 9, 5, 0, 1, 0, 4'b0000, 0);
        expect_out("no_match", 2'b00, 2'b00, 0, 0, 0, 0);
        drive(0, 1, 1, 6, 0, 1, 1, 4'b0000, 0);
        expect_out("fwd_mem", 2'b10, 2'b00, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 1, 4'b0000, 0);
        expect_out("fwd_wb", 2'b01, 2'b01, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 4'b0000, 0);
        drive(0, 1, 3, 7, 0, 0, 0, 4'b0000, 0);
        drive(0, 0, 0, 15, 0, 1, 1, 4'b0000, 0);
        expect_out("fwd_priority", 2'b10, 2'b00, 0, 0, 0, 0);
        drive(0, 15, 15, 2, 0, 0, 0, 4'b0000, 0);
        drive(0, 3, 4, 2, 0, 1, 1, 4'b0000, 0);
        expect_out("r15_no_fwd", 2'b00, 2'b00, 0, 0, 0, 0);

        // Load-use stall
        drive(0, 0, 2, 8, 1, 0, 0, 4'b0000, 0);
        expect_out("ldr_stall", 2'b00, 2'b00, 1, 1, 0, 1);
        drive(0, 0, 2, 8, 0, 0, 0, 4'b0000, 0);
        expect_out("ldr_release", 2'b00, 2'b00, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 4'b0000, 0);
        expect_out("ldr_fwd_wb", 2'b00, 2'b01, 0, 0, 0, 0);

        // PC write marching through the pipeline
        drive(0, 0, 0, 0, 0, 0, 0, 4'b1000, 0);
        expect_out("pc_d", 2'b00, 2'b00, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 4'b0100, 0);
        expect_out("pc_e", 2'b00, 2'b00, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 4'b0010, 0);
        expect_out("pc_m", 2'b00, 2'b00, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 4'b0001, 0);
        expect_out("pc_w", 2'b00, 2'b00, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        expect_out("pc_done", 2'b00, 2'b00, 0, 0, 0, 0);

        // Branch taken together with a load-use stall
        drive(0, 1, 1, 9, 0, 0, 0, 4'b0000, 0);
        drive(0, 9, 0, 10, 1, 0, 0, 4'b0000, 1);
        expect_out("br_ldr", 2'b00, 2'b00, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 1, 1, 0, 4'b0000, 0);
        expect_out("br_ldr_next", 2'b00, 2'b00, 0, 0, 0, 0);

        // Reset during a load stall
        drive(0, 0, 0, 0, 1, 0, 0, 4'b0000, 0);
        expect_out("stall_pre_reset", 2'b00, 2'b00, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        drive(1, 0, 0, 0, 1, 0, 0, 4'b0000, 0);
        expect_out("reset_mid_stall", 2'b00, 2'b00, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        drive(0, 0, 0, 0, 1, 1, 1, 4'b0000, 0);
        expect_out("valid_after_release", 2'b00, 2'b00, 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        done = 1'b1;
    end

endmodule : tb_hazard_unit
`default_nettype wire
